memory_stage: RTL and testbench

- Pipeline stage directly downstream of execute; consumes the execute-stage output bundle.
- Loads/stores: issues one data-memory request using result_data as effective address, then aligns and extends load data.
- All other ops: passes the result through unchanged.
- Drives the writeback stage using the stall/done handshake shared by all pipeline stages.

---
 rtl/pipeline_pkg.sv | 60 ++++++
 rtl/load_store_align.sv | 57 +++++
 rtl/memory_stage.sv | 184 ++++++++++++++++++
 tb/tb_memory_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipeline_pkg                                                         |
// | Shared widths, funct3 encodings, memory-stage states, access sizes.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package pipeline_pkg;

    localparam int ADDR_WIDTH              = 32;
    localparam int DATA_WIDTH              = 32;
    localparam int REGISTER_INDEXING_WIDTH = $clog2(32);

    localparam logic [2:0] c_F3_LB  = 3'd0;
    localparam logic [2:0] c_F3_LH  = 3'd1;
    localparam logic [2:0] c_F3_LW  = 3'd2;
    localparam logic [2:0] c_F3_LBU = 3'd4;
    localparam logic [2:0] c_F3_LHU = 3'd5;
    localparam logic [2:0] c_F3_SB  = 3'd0;
    localparam logic [2:0] c_F3_SH  = 3'd1;
    localparam logic [2:0] c_F3_SW  = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PASS = 3'd1,
        ST_REQ  = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } access_size_e;

    function automatic logic funct3_illegal(input logic is_store, input logic [2:0] funct3);
        if (is_store)
            return funct3 > c_F3_SW;
        return !(funct3 == c_F3_LB || funct3 == c_F3_LH || funct3 == c_F3_LW ||
                 funct3 == c_F3_LBU || funct3 == c_F3_LHU);
    endfunction

    function automatic access_size_e access_size(input logic [2:0] funct3);
        case (funct3[1:0])
            2'd0:    return SIZE_BYTE;
            2'd1:    return SIZE_HALF;
            default: return SIZE_WORD;
        endcase
    endfunction

    function automatic logic addr_misaligned(input logic [2:0] funct3, input logic [1:0] addr);
        case (access_size(funct3))
            SIZE_HALF: return addr[0];
            SIZE_WORD: return addr != 2'b00;
            default:   return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | load_store_align                                                     |
// | Store lane placement, load extraction/extension and fault detection. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module load_store_align
    import pipeline_pkg::*;
(
    input  logic                  is_store,
    input  logic [2:0]            funct3,
    input  logic [1:0]            addr,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic [3:0]            wstrb,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  misaligned,
    output logic                  illegal
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        illegal    = funct3_illegal(is_store, funct3);
        // Alignment is meaningless without a legal access size.
        misaligned = !illegal && addr_misaligned(funct3, addr);

        w_byte = read_data[{addr, 3'b000} +: 8];
        w_half = read_data[{addr[1], 4'b0000} +: 16];

        wstrb = 4'b1111;
        wdata = store_data;
        case (funct3)
            c_F3_SB: begin
                wstrb = 4'b0001 << addr;
                wdata = {4{store_data[7:0]}};
            end
            c_F3_SH: begin
                wstrb = 4'b0011 << {addr[1], 1'b0};
                wdata = {2{store_data[15:0]}};
            end
            default: ;
        endcase

        case (funct3)
            c_F3_LB:  load_data = {{24{w_byte[7]}}, w_byte};
            c_F3_LH:  load_data = {{16{w_half[15]}}, w_half};
            c_F3_LBU: load_data = {24'd0, w_byte};
            c_F3_LHU: load_data = {16'd0, w_half};
            default:  load_data = read_data;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/memory_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | memory_stage                                                         |
// | Issues data-memory requests for loads/stores, passes other ops on.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module memory_stage
    import pipeline_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst,
    output logic                               stall_prev,
    input  logic                               prev_done,
    input  logic                               next_stall,
    output logic                               done_next,
    input  logic [ADDR_WIDTH-1:0]              program_count_in,
    input  logic                               program_count_valid_in,
    input  logic                               register_arith_in,
    input  logic                               immediate_arith_in,
    input  logic                               load_in,
    input  logic                               store_in,
    input  logic                               branch_in,
    input  logic                               immediate_jump_in,
    input  logic                               register_jump_in,
    input  logic                               load_upper_in,
    input  logic                               load_upper_pc_in,
    input  logic                               environment_in,
    input  logic                               opcode_legal_in,
    input  logic [2:0]                         funct_3_in,
    input  logic                               funct_3_valid_in,
    input  logic [REGISTER_INDEXING_WIDTH-1:0] write_register_in,
    input  logic                               write_register_valid_in,
    input  logic [DATA_WIDTH-1:0]              memory_store_data_in,
    input  logic                               memory_store_data_valid_in,
    input  logic [DATA_WIDTH-1:0]              result_data_in,
    input  logic                               result_data_valid_in,
    output logic                               mem_req_valid,
    input  logic                               mem_req_ready,
    output logic [ADDR_WIDTH-1:0]              mem_req_addr,
    output logic                               mem_req_write,
    output logic [DATA_WIDTH-1:0]              mem_req_wdata,
    output logic [3:0]                         mem_req_wstrb,
    input  logic                               mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]              mem_resp_rdata,
    output logic [ADDR_WIDTH-1:0]              program_count_out,
    output logic                               program_count_valid_out,
    output logic                               register_arith_out,
    output logic                               immediate_arith_out,
    output logic                               load_out,
    output logic                               store_out,
    output logic                               branch_out,
    output logic                               immediate_jump_out,
    output logic                               register_jump_out,
    output logic                               load_upper_out,
    output logic                               load_upper_pc_out,
    output logic                               environment_out,
    output logic                               opcode_legal_out,
    output logic [REGISTER_INDEXING_WIDTH-1:0] write_register_out,
    output logic                               write_register_valid_out,
    output logic [DATA_WIDTH-1:0]              writeback_data_out,
    output logic                               writeback_data_valid_out,
    output logic                               misaligned_out,
    output logic                               access_illegal_out
);

    state_e                             r_state;
    state_e                             w_state_next;
    state_e                             w_accept_state;
    logic [10:0]                        r_flags;
    logic [ADDR_WIDTH-1:0]              r_pc;
    logic                               r_pc_valid;
    logic [2:0]                         r_funct3;
    logic [REGISTER_INDEXING_WIDTH-1:0] r_wr;
    logic                               r_wr_valid;
    logic [DATA_WIDTH-1:0]              r_store_data;
    logic [DATA_WIDTH-1:0]              r_result;
    logic                               r_result_valid;
    logic [DATA_WIDTH-1:0]              r_rdata;

    logic                  w_transfer_next;
    logic                  w_accept;
    logic                  w_in_fault;
    logic                  w_mem_op;
    logic                  w_misaligned;
    logic                  w_illegal;
    logic [DATA_WIDTH-1:0] w_load_data;
    logic                  w_unused_ok;

    assign w_unused_ok = &{1'b0, funct_3_valid_in, memory_store_data_valid_in};

    assign done_next       = !rst && (r_state == ST_PASS || r_state == ST_DONE);
    assign w_transfer_next = done_next && !next_stall;
    assign stall_prev      = rst || (r_state != ST_IDLE && !w_transfer_next);
    // stall_prev already excludes REQ/WAIT and held PASS/DONE, so any handshake is an accept.
    assign w_accept        = prev_done && !stall_prev;

    assign w_in_fault = funct3_illegal(store_in, funct_3_in) ||
                        addr_misaligned(funct_3_in, result_data_in[1:0]);

    always_comb begin
        w_accept_state = ST_PASS;
        if (load_in || store_in)
            w_accept_state = w_in_fault ? ST_DONE : ST_REQ;

        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_next = w_accept_state;
            ST_PASS,
            ST_DONE: if (w_transfer_next) w_state_next = w_accept ? w_accept_state : ST_IDLE;
            ST_REQ:  if (mem_req_ready) w_state_next = ST_WAIT;
            ST_WAIT: if (mem_resp_valid) w_state_next = ST_DONE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_flags <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept)
                r_flags <= {register_arith_in, immediate_arith_in, load_in, store_in, branch_in,
                            immediate_jump_in, register_jump_in, load_upper_in, load_upper_pc_in,
                            environment_in, opcode_legal_in};
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_pc           <= program_count_in;
            r_pc_valid     <= program_count_valid_in;
            r_funct3       <= funct_3_in;
            r_wr           <= write_register_in;
            r_wr_valid     <= write_register_valid_in;
            r_store_data   <= memory_store_data_in;
            r_result       <= result_data_in;
            r_result_valid <= result_data_valid_in;
        end
        if (r_state == ST_WAIT && mem_resp_valid)
            r_rdata <= mem_resp_rdata;
    end

    assign {register_arith_out, immediate_arith_out, load_out, store_out, branch_out,
            immediate_jump_out, register_jump_out, load_upper_out, load_upper_pc_out,
            environment_out, opcode_legal_out} = r_flags;

    load_store_align u_align (
        .is_store   (store_out),
        .funct3     (r_funct3),
        .addr       (r_result[1:0]),
        .store_data (r_store_data),
        .read_data  (r_rdata),
        .wstrb      (mem_req_wstrb),
        .wdata      (mem_req_wdata),
        .load_data  (w_load_data),
        .misaligned (w_misaligned),
        .illegal    (w_illegal)
    );

    assign w_mem_op      = load_out || store_out;
    assign mem_req_valid = !rst && r_state == ST_REQ;
    assign mem_req_addr  = {r_result[ADDR_WIDTH-1:2], 2'b00};
    assign mem_req_write = store_out;

    assign misaligned_out     = !rst && w_mem_op && w_misaligned;
    assign access_illegal_out = !rst && w_mem_op && w_illegal;

    assign program_count_out        = r_pc;
    assign program_count_valid_out  = r_pc_valid;
    assign write_register_out       = r_wr;
    assign write_register_valid_out = r_wr_valid;
    assign writeback_data_out       = load_out ? w_load_data : r_result;

    always_comb begin
        writeback_data_valid_out = r_result_valid;
        if (load_out)
            writeback_data_valid_out = !(w_misaligned || w_illegal);
        else if (store_out || branch_out || environment_out)
            writeback_data_valid_out = 1'b0;
    end

endmodule
`default_nettype wire

// File: tb/tb_memory_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_memory_stage                                                      |
// | Directed self-checking bench for memory_stage.                       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst, stall_prev, prev_done, next_stall, done_next;
    logic [31:0] program_count_in;
    logic        program_count_valid_in;
    logic        register_arith_in, immediate_arith_in, load_in, store_in, branch_in;
    logic        immediate_jump_in, register_jump_in, load_upper_in, load_upper_pc_in;
    logic        environment_in, opcode_legal_in;
    logic [2:0]  funct_3_in;
    logic        funct_3_valid_in;
    logic [4:0]  write_register_in;
    logic        write_register_valid_in;
    logic [31:0] memory_store_data_in;
    logic        memory_store_data_valid_in;
    logic [31:0] result_data_in;
    logic        result_data_valid_in;
    logic        mem_req_valid, mem_req_ready, mem_req_write;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic [31:0] program_count_out;
    logic        program_count_valid_out;
    logic        register_arith_out, immediate_arith_out, load_out, store_out, branch_out;
    logic        immediate_jump_out, register_jump_out, load_upper_out, load_upper_pc_out;
    logic        environment_out, opcode_legal_out;
    logic [4:0]  write_register_out;
    logic        write_register_valid_out;
    logic [31:0] writeback_data_out;
    logic        writeback_data_valid_out, misaligned_out, access_illegal_out;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    memory_stage dut (
        .clk(clk), .rst(rst), .stall_prev(stall_prev), .prev_done(prev_done),
        .next_stall(next_stall), .done_next(done_next),
        .program_count_in(program_count_in), .program_count_valid_in(program_count_valid_in),
        .register_arith_in(register_arith_in), .immediate_arith_in(immediate_arith_in),
        .load_in(load_in), .store_in(store_in), .branch_in(branch_in),
        .immediate_jump_in(immediate_jump_in), .register_jump_in(register_jump_in),
        .load_upper_in(load_upper_in), .load_upper_pc_in(load_upper_pc_in),
        .environment_in(environment_in), .opcode_legal_in(opcode_legal_in),
        .funct_3_in(funct_3_in), .funct_3_valid_in(funct_3_valid_in),
        .write_register_in(write_register_in), .write_register_valid_in(write_register_valid_in),
        .memory_store_data_in(memory_store_data_in),
        .memory_store_data_valid_in(memory_store_data_valid_in),
        .result_data_in(result_data_in), .result_data_valid_in(result_data_valid_in),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_write(mem_req_write),
        .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
        .program_count_out(program_count_out), .program_count_valid_out(program_count_valid_out),
        .register_arith_out(register_arith_out), .immediate_arith_out(immediate_arith_out),
        .load_out(load_out), .store_out(store_out), .branch_out(branch_out),
        .immediate_jump_out(immediate_jump_out), .register_jump_out(register_jump_out),
        .load_upper_out(load_upper_out), .load_upper_pc_out(load_upper_pc_out),
        .environment_out(environment_out), .opcode_legal_out(opcode_legal_out),
        .write_register_out(write_register_out),
        .write_register_valid_out(write_register_valid_out),
        .writeback_data_out(writeback_data_out),
        .writeback_data_valid_out(writeback_data_valid_out),
        .misaligned_out(misaligned_out), .access_illegal_out(access_illegal_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        prev_done = 0; next_stall = 0; program_count_in = 0; program_count_valid_in = 0;
        {register_arith_in, immediate_arith_in, load_in, store_in, branch_in, immediate_jump_in,
         register_jump_in, load_upper_in, load_upper_pc_in, environment_in, opcode_legal_in} = '0;
        funct_3_in = 0; funct_3_valid_in = 0; write_register_in = 0; write_register_valid_in = 0;
        memory_store_data_in = 0; memory_store_data_valid_in = 0;
        result_data_in = 0; result_data_valid_in = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = 0;
    endtask

    task automatic drive_op(input logic ld, input logic st, input logic ra, input logic [2:0] f3,
                            input logic [31:0] res, input logic [31:0] sdata, input logic [4:0] rd);
        prev_done = 1; program_count_in = 32'h1000_0040; program_count_valid_in = 1;
        register_arith_in = ra; load_in = ld; store_in = st; opcode_legal_in = 1;
        funct_3_in = f3; funct_3_valid_in = 1; write_register_in = rd; write_register_valid_in = 1;
        memory_store_data_in = sdata; memory_store_data_valid_in = 1;
        result_data_in = res; result_data_valid_in = 1;
    endtask

    task automatic test_reset();
        rst = 1; clear_inputs();
        tick(); tick();
        n_cmp++; if (stall_prev !== 1'b1) begin n_err++; $display("FAIL rst_stall: got %b want 1", stall_prev); end
        n_cmp++; if (done_next !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", done_next); end
        n_cmp++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", mem_req_valid); end
        n_cmp++; if ({misaligned_out, access_illegal_out} !== 2'b00) begin n_err++; $display("FAIL rst_fault: got %b want 00", {misaligned_out, access_illegal_out}); end
        rst = 0; tick();
        n_cmp++; if (stall_prev !== 1'b0) begin n_err++; $display("FAIL idle_stall: got %b want 0", stall_prev); end
    endtask

    task automatic test_pass();
        drive_op(0, 0, 1, 3'd0, 32'h0000_0055, 32'h0, 5'd7);
        tick();
        clear_inputs();
        n_cmp++; if (done_next !== 1'b1) begin n_err++; $display("FAIL pass_done: got %b want 1", done_next); end
        n_cmp++; if (writeback_data_out !== 32'h55) begin n_err++; $display("FAIL pass_wb: got %h want 00000055", writeback_data_out); end
        n_cmp++; if (writeback_data_valid_out !== 1'b1) begin n_err++; $display("FAIL pass_wbv: got %b want 1", writeback_data_valid_out); end
        n_cmp++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL pass_req: got %b want 0", mem_req_valid); end
        n_cmp++; if ({write_register_out, program_count_out} !== {5'd7, 32'h1000_0040}) begin n_err++; $display("FAIL pass_fwd: got %h/%h want 07/10000040", write_register_out, program_count_out); end
        tick();
        n_cmp++; if (done_next !== 1'b0) begin n_err++; $display("FAIL pass_idle: got %b want 0", done_next); end
    endtask

    task automatic test_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] exp);
        drive_op(1, 0, 0, f3, addr, 32'h0, 5'd3);
        tick();
        clear_inputs();
        n_cmp++; if ({mem_req_valid, mem_req_write, done_next} !== 3'b100) begin n_err++; $display("FAIL ld_req f3=%0d: got v/w/d %b want 100", f3, {mem_req_valid, mem_req_write, done_next}); end
        n_cmp++; if (mem_req_addr !== {addr[31:2], 2'b00}) begin n_err++; $display("FAIL ld_addr f3=%0d: got %h want %h", f3, mem_req_addr, {addr[31:2], 2'b00}); end
        mem_req_ready = 1; tick(); mem_req_ready = 0;
        n_cmp++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL ld_wait f3=%0d: got %b want 0", f3, mem_req_valid); end
        mem_resp_valid = 1; mem_resp_rdata = 32'h80FF_1234; tick(); mem_resp_valid = 0;
        n_cmp++; if (done_next !== 1'b1) begin n_err++; $display("FAIL ld_done f3=%0d: got %b want 1", f3, done_next); end
        n_cmp++; if ({writeback_data_valid_out, writeback_data_out} !== {1'b1, exp}) begin n_err++; $display("FAIL ld_data f3=%0d: got %b/%h want 1/%h", f3, writeback_data_valid_out, writeback_data_out, exp); end
        tick();
    endtask

    task automatic test_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] exp_strb, input logic [31:0] exp_wdata, input int stalls);
        drive_op(0, 1, 0, f3, addr, data, 5'd0);
        tick();
        clear_inputs();
        for (int i = 0; i <= stalls; i++) begin
            if (i == stalls) mem_req_ready = 1;
            n_cmp++; if ({mem_req_valid, mem_req_write, mem_req_addr} !== {2'b11, addr[31:2], 2'b00}) begin n_err++; $display("FAIL st_req f3=%0d cyc=%0d: got %b%b %h", f3, i, mem_req_valid, mem_req_write, mem_req_addr); end
            n_cmp++; if ({mem_req_wstrb, mem_req_wdata} !== {exp_strb, exp_wdata}) begin n_err++; $display("FAIL st_lane f3=%0d cyc=%0d: got %b/%h want %b/%h", f3, i, mem_req_wstrb, mem_req_wdata, exp_strb, exp_wdata); end
            tick();
        end
        mem_req_ready = 0; mem_resp_valid = 1; tick(); mem_resp_valid = 0;
        n_cmp++; if ({done_next, writeback_data_valid_out} !== 2'b10) begin n_err++; $display("FAIL st_done f3=%0d: got %b want 10", f3, {done_next, writeback_data_valid_out}); end
        tick();
    endtask

    task automatic test_faults();
        drive_op(1, 0, 0, 3'd2, 32'h0000_0301, 32'h0, 5'd4);
        tick(); clear_inputs();
        n_cmp++; if ({misaligned_out, access_illegal_out, done_next, mem_req_valid, writeback_data_valid_out} !== 5'b10100) begin n_err++; $display("FAIL lw_mis: got m/i/d/r/v %b want 10100", {misaligned_out, access_illegal_out, done_next, mem_req_valid, writeback_data_valid_out}); end
        tick();
        n_cmp++; if ({mem_req_valid, done_next} !== 2'b00) begin n_err++; $display("FAIL lw_mis_idle: got %b want 00", {mem_req_valid, done_next}); end
        drive_op(1, 0, 0, 3'd3, 32'h0000_0300, 32'h0, 5'd4);
        tick(); clear_inputs();
        n_cmp++; if ({misaligned_out, access_illegal_out, done_next, mem_req_valid} !== 4'b0110) begin n_err++; $display("FAIL ld_ill: got m/i/d/r %b want 0110", {misaligned_out, access_illegal_out, done_next, mem_req_valid}); end
        tick();
        drive_op(0, 1, 0, 3'd4, 32'h0000_0300, 32'h0, 5'd0);
        tick(); clear_inputs();
        n_cmp++; if ({misaligned_out, access_illegal_out, done_next, mem_req_valid} !== 4'b0110) begin n_err++; $display("FAIL st_ill: got m/i/d/r %b want 0110", {misaligned_out, access_illegal_out, done_next, mem_req_valid}); end
        tick();
    endtask

    task automatic test_back_to_back();
        drive_op(0, 0, 1, 3'd0, 32'h11, 32'h0, 5'd1);
        tick();
        drive_op(0, 0, 1, 3'd0, 32'h22, 32'h0, 5'd2);
        next_stall = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++; if ({stall_prev, done_next} !== 2'b11) begin n_err++; $display("FAIL b2b_stall cyc=%0d: got %b want 11", i, {stall_prev, done_next}); end
            n_cmp++; if ({write_register_out, writeback_data_out} !== {5'd1, 32'h11}) begin n_err++; $display("FAIL b2b_hold cyc=%0d: got %h/%h want 01/00000011", i, write_register_out, writeback_data_out); end
            tick();
        end
        next_stall = 0; #1;
        n_cmp++; if (stall_prev !== 1'b0) begin n_err++; $display("FAIL b2b_release: got %b want 0", stall_prev); end
        tick(); clear_inputs();
        n_cmp++; if ({done_next, write_register_out, writeback_data_out} !== {1'b1, 5'd2, 32'h22}) begin n_err++; $display("FAIL b2b_second: got %b/%h/%h want 1/02/00000022", done_next, write_register_out, writeback_data_out); end
        tick();
        n_cmp++; if (done_next !== 1'b0) begin n_err++; $display("FAIL b2b_nodup: got %b want 0", done_next); end
    endtask

    task automatic test_reset_in_wait();
        drive_op(1, 0, 0, 3'd2, 32'h0000_0400, 32'h0, 5'd5);
        tick(); clear_inputs();
        mem_req_ready = 1; tick(); mem_req_ready = 0;
        rst = 1; #1;
        n_cmp++; if ({stall_prev, mem_req_valid} !== 2'b10) begin n_err++; $display("FAIL rw_rst: got %b want 10", {stall_prev, mem_req_valid}); end
        tick(); rst = 0;
        mem_resp_valid = 1; mem_resp_rdata = 32'hDEAD_BEEF; #1;
        n_cmp++; if ({done_next, stall_prev} !== 2'b00) begin n_err++; $display("FAIL rw_idle: got %b want 00", {done_next, stall_prev}); end
        tick(); mem_resp_valid = 0;
        n_cmp++; if ({done_next, mem_req_valid, stall_prev} !== 3'b000) begin n_err++; $display("FAIL rw_stray: got %b want 000", {done_next, mem_req_valid, stall_prev}); end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_pass();
        test_load(3'd0, 32'h0000_0103, 32'hFFFF_FF80);
        test_load(3'd4, 32'h0000_0103, 32'h0000_0080);
        test_load(3'd1, 32'h0000_0102, 32'hFFFF_80FF);
        test_load(3'd5, 32'h0000_0100, 32'h0000_1234);
        test_load(3'd2, 32'h0000_0100, 32'h80FF_1234);
        test_store(3'd1, 32'h0000_0202, 32'hABCD_BEEF, 4'b1100, 32'hBEEF_BEEF, 3);
        test_store(3'd0, 32'h0000_0201, 32'h1234_56EF, 4'b0010, 32'hEFEF_EFEF, 0);
        test_store(3'd2, 32'h0000_0204, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 1);
        test_faults();
        test_back_to_back();
        test_reset_in_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
